instr_queue_reader: RTL
=======================

// Module: instr_queue_reader
// PURPOSE
//  Consumer/read end of the dual-data show-ahead FIFO (data0 = 32b instruction, data1 = 8b tag).
//  Pops entries into a 2-entry output buffer and presents them downstream on a valid/ready handshake.
//  On flush, drains and discards all FIFO contents. Sits between the instruction FIFO and decode/dispatch.
// PARAMETERS
//  DATA0SIZE  32  width of payload word 0 (instruction)
//  DATA1SIZE  8   width of payload word 1 (tag/ID)
//  CNTW       16  width of perf counters (used only with IQR_PERF_CNT_EN)
// PORTS
//  clk            in   1          rising-edge clock
//  rstn           in   1          asynchronous active-low reset
//  i_data0        in   DATA0SIZE  FIFO head word 0 (valid combinationally while ~i_Empty)
//  i_data1        in   DATA1SIZE  FIFO head word 1
//  i_Empty        in   1          FIFO empty flag
//  o_RdEn         out  1          FIFO pop; head advances at the same clock edge
//  i_flush        in   1          discard buffer and drain FIFO
//  o_valid        out  1          downstream entry valid
//  o_data0        out  DATA0SIZE  downstream word 0
//  o_data1        out  DATA1SIZE  downstream word 1
//  i_ready        in   1          downstream accept
//  o_flushing     out  1          high while in FLUSH state
//  o_pop_cnt      out  CNTW       entries delivered (0 without macro)
//  o_stall_cnt    out  CNTW       cycles with o_valid & ~i_ready (0 without macro)
// BEHAVIOUR
//  - Reset: state=RUN, buffer count=0, o_valid=0, o_RdEn=0, o_data0/o_data1=0, o_flushing=0, counters=0.
//  - FIFO contract: show-ahead read. Data present on i_data* when ~i_Empty is captured at the same edge o_RdEn is high.
//  - Buffer: 2 entries, registered count 0..2. o_valid = (count != 0). o_data* = head entry, driven from registers.
//  - RUN: o_RdEn = ~i_Empty & (count < 2) & ~i_flush. This is a function of registered count only;
//    there is no combinational path from i_ready to o_RdEn.
//  - Transfer: out = o_valid & i_ready; in = o_RdEn. Next count = count + in - out.
//    Simultaneous in and out with count=2 is impossible, because in requires count<2.
//    With count=1 and both in and out: the new entry becomes head, count stays 1.
//  - Latency: FIFO nonempty in cycle N with count=0 -> o_valid=1 in cycle N+1.
//    Sustained throughput is 1 entry/clk while i_ready=1.
//  - Order: strict FIFO. Entries are never dropped or duplicated outside flush.
//  - Held outputs: while o_valid & ~i_ready, o_data* are held stable.
//  - Flush in RUN (i_flush=1): next edge count=0, o_valid=0, state=FLUSH. No pop that cycle.
//  - FLUSH: o_RdEn = ~i_Empty. Popped data is discarded. o_valid=0, o_flushing=1.
//    Exit to RUN at the edge where i_Empty=1 & i_flush=0.
//    i_flush held high keeps the block in FLUSH.
//  - i_ready is ignored while count=0 or in FLUSH.
//  - Reset asserted mid-operation returns all state to reset values immediately (async).
//    The FIFO is reset by the same rstn.
// CONFIGURATION
//  - IQR_PERF_CNT_EN defined:
//    o_pop_cnt increments on each out; o_stall_cnt increments on each o_valid & ~i_ready cycle.
//    Both saturate at all-ones and clear on rstn and on i_flush.
//  - IQR_PERF_CNT_EN undefined: counters are not built; o_pop_cnt and o_stall_cnt are tied to 0.
//  - Port list is identical in both builds.
// STRUCTURE
//  - Package iq_pkg:
//    - typedef struct packed {logic [DATA0SIZE-1:0] data0; logic [DATA1SIZE-1:0] data1;} iq_entry_t (shared with the FIFO);
//    - typedef enum logic {IQR_RUN, IQR_FLUSH} iqr_state_t;
//    - localparam IQR_BUF_DEPTH = 2.
//  - Sub-module iqr_skid_buf2: 2-entry buffer with count, push, pop and clear. The top level holds the FSM, o_RdEn and counters.
// TESTING
//  - Reset, then push 1/2..10/11 into FIFO with i_ready=1 -> o_valid from cycle after first nonempty; 10 beats in order 1/2..10/11, one per clk.
//  - 4 entries pushed, i_ready=0 -> exactly 2 pops, o_RdEn=0 after, o_data0=1 held; raise i_ready -> remaining 1..4 order intact.
//  - Toggle i_ready 1,0,1,0 on a 6-entry stream -> no loss/duplication, o_data stable while stalled.
//  - 5 entries queued, count=2, pulse i_flush -> o_valid=0 next clk, o_flushing=1, FIFO drains to empty, RUN re-entered; new push 0xAA/0x55 delivered.
//  - rstn low mid-stream with count=2 -> o_valid=0, o_RdEn=0 immediately; no stale entry after rstn release.
//  - IQR_PERF_CNT_EN: 3 delivered beats + 4 stall cycles -> o_pop_cnt=3, o_stall_cnt=4. Without the macro, both read 0.

Source files
------------

// File: rtl/iq_pkg.sv
// -----------------------------------------------------------------------------
// iq_pkg
// Shared types and constants for the instruction queue read side.
//   iq_entry_t    : one FIFO entry (instruction word + tag), same layout as the
//                   instruction FIFO uses.
//   iqr_state_t   : reader control state (normal operation / flushing).
//   IQR_BUF_DEPTH : number of entries in the reader's output buffer.
// -----------------------------------------------------------------------------
package iq_pkg;

    localparam int IQ_DATA0SIZE  = 32;
    localparam int IQ_DATA1SIZE  = 8;
    localparam int IQR_BUF_DEPTH = 2;

    typedef struct packed {
        logic [IQ_DATA0SIZE-1:0] data0;
        logic [IQ_DATA1SIZE-1:0] data1;
    } iq_entry_t;

    typedef enum logic {
        IQR_RUN,
        IQR_FLUSH
    } iqr_state_t;

endpackage

// File: rtl/instr_queue_reader_if.sv
// -----------------------------------------------------------------------------
// instr_queue_reader_if
// Downstream entry handshake of the instruction queue reader.
//   valid : entry on data0/data1 is meaningful
//   data0 : instruction word (W0 bits)
//   data1 : tag / ID (W1 bits)
//   ready : consumer can take the entry this cycle
// Handshake: an entry transfers on every rising clock edge where valid and
// ready are both high. valid never depends on ready; while valid is high and
// ready is low, valid and data are held stable until the transfer happens.
// Modports: master = producer (reader), slave = consumer (decode/dispatch).
// -----------------------------------------------------------------------------
interface instr_queue_reader_if #(
    parameter int W0 = 32,
    parameter int W1 = 8
);
    logic          valid;
    logic [W0-1:0] data0;
    logic [W1-1:0] data1;
    logic          ready;

    modport master (output valid, output data0, output data1, input ready);
    modport slave  (input valid, input data0, input data1, output ready);
endinterface

// File: rtl/iqr_skid_buf2.sv
// -----------------------------------------------------------------------------
// iqr_skid_buf2
// Two-entry in-order output buffer between the FIFO read port and downstream.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   push             : load push_data0/push_data1 this edge (ignored when full)
//   push_data0/1     : entry being loaded
//   clear            : discard all entries (wins over push and pop)
//   count            : registered occupancy, 0..2
//   dn (master)      : downstream handshake; head entry presented from regs
// A pop happens internally on dn.valid & dn.ready.
// -----------------------------------------------------------------------------
module iqr_skid_buf2
    import iq_pkg::*;
#(
    parameter int W0 = 32,
    parameter int W1 = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [W0-1:0]        push_data0,
    input  logic [W1-1:0]        push_data1,
    input  logic                 clear,
    output logic [1:0]           count,
    instr_queue_reader_if.master dn
);

    logic [W0-1:0] d0_q [IQR_BUF_DEPTH];
    logic [W1-1:0] d1_q [IQR_BUF_DEPTH];
    logic [1:0]    cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~clear & (cnt_q != 2'(IQR_BUF_DEPTH));
    assign do_pop  = (cnt_q != 2'd0) & dn.ready & ~clear;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < IQR_BUF_DEPTH; i++) begin
                d0_q[i] <= '0;
                d1_q[i] <= '0;
            end
        end else if (clear) begin
            cnt_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                // Push and pop together only happen at count 1: the new
                // entry replaces the departing head, occupancy unchanged.
                2'b11: begin
                    d0_q[0] <= push_data0;
                    d1_q[0] <= push_data1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        d0_q[0] <= push_data0;
                        d1_q[0] <= push_data1;
                    end else begin
                        d0_q[1] <= push_data0;
                        d1_q[1] <= push_data1;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    d0_q[0] <= d0_q[1];
                    d1_q[0] <= d1_q[1];
                    cnt_q   <= cnt_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign count    = cnt_q;
    assign dn.valid = (cnt_q != 2'd0);
    assign dn.data0 = d0_q[0];
    assign dn.data1 = d1_q[0];

endmodule

// File: rtl/instr_queue_reader.sv
// -----------------------------------------------------------------------------
// instr_queue_reader
// Read end of the show-ahead instruction FIFO. Pops entries into a 2-entry
// output buffer and offers them downstream on a valid/ready handshake. A flush
// discards the buffer and drains the FIFO until it is empty.
// Ports:
//   clk, rstn          : clock, asynchronous active-low reset (FIFO shares it)
//   i_data0/i_data1    : FIFO head entry (valid while ~i_Empty)
//   i_Empty            : FIFO empty flag
//   o_RdEn             : FIFO pop, head advances on the same edge
//   i_flush            : discard buffer and drain FIFO
//   o_valid/o_data0/o_data1/i_ready : downstream handshake
//   o_flushing         : high while in the FLUSH state (control state view)
//   o_pop_cnt          : entries delivered (performance counter)
//   o_stall_cnt        : cycles with o_valid & ~i_ready (performance counter)
// Build option: IQR_PERF_CNT_EN builds the saturating performance counters;
// without it o_pop_cnt and o_stall_cnt are tied to zero.
// -----------------------------------------------------------------------------
module instr_queue_reader
    import iq_pkg::*;
#(
    parameter int DATA0SIZE = IQ_DATA0SIZE,
    parameter int DATA1SIZE = IQ_DATA1SIZE,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA0SIZE-1:0] i_data0,
    input  logic [DATA1SIZE-1:0] i_data1,
    input  logic                 i_Empty,
    output logic                 o_RdEn,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [DATA0SIZE-1:0] o_data0,
    output logic [DATA1SIZE-1:0] o_data1,
    input  logic                 i_ready,
    output logic                 o_flushing,
    output logic [CNTW-1:0]      o_pop_cnt,
    output logic [CNTW-1:0]      o_stall_cnt
);

    iqr_state_t state_q, state_d;
    logic       rd_en;
    logic       buf_clear;
    logic       buf_push;
    logic [1:0] buf_count;

    instr_queue_reader_if #(.W0(DATA0SIZE), .W1(DATA1SIZE)) dn_if ();

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IQR_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pop decision uses only the registered buffer count, so there is no
    // combinational path from i_ready to o_RdEn.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            IQR_RUN: begin
                if (i_flush) begin
                    buf_clear = 1'b1;
                    state_d   = IQR_FLUSH;
                end else begin
                    rd_en = ~i_Empty & (buf_count != 2'(IQR_BUF_DEPTH));
                end
            end
            IQR_FLUSH: begin
                // Drain and discard; the buffer stays empty.
                rd_en     = ~i_Empty;
                buf_clear = 1'b1;
                if (i_Empty && !i_flush) begin
                    state_d = IQR_RUN;
                end
            end
            default: state_d = IQR_RUN;
        endcase
    end

    assign buf_push = rd_en & (state_q == IQR_RUN);

    iqr_skid_buf2 #(.W0(DATA0SIZE), .W1(DATA1SIZE)) u_buf (
        .clk        (clk),
        .rstn       (rstn),
        .push       (buf_push),
        .push_data0 (i_data0),
        .push_data1 (i_data1),
        .clear      (buf_clear),
        .count      (buf_count),
        .dn         (dn_if)
    );

    assign dn_if.ready = i_ready;
    assign o_valid     = dn_if.valid;
    assign o_data0     = dn_if.data0;
    assign o_data1     = dn_if.data1;
    assign o_RdEn      = rd_en;
    assign o_flushing  = (state_q == IQR_FLUSH);

`ifdef IQR_PERF_CNT_EN
    logic [CNTW-1:0] pop_cnt_q;
    logic [CNTW-1:0] stall_cnt_q;
    logic            beat_out;
    logic            beat_stall;

    assign beat_out   = dn_if.valid & i_ready;
    assign beat_stall = dn_if.valid & ~i_ready;

    // Saturating counters; a flush restarts the measurement window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (i_flush) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (beat_out && (pop_cnt_q != {CNTW{1'b1}})) begin
                pop_cnt_q <= pop_cnt_q + 1'b1;
            end
            if (beat_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign o_pop_cnt   = pop_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_pop_cnt   = '0;
    assign o_stall_cnt = '0;
`endif

endmodule
